// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with byte strobes, write-to-read bypass, busy scoreboard and post-reset clear.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_WR*DATA_W/8-1:0] wstrb,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic                       ready
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB = DATA_W/8;
  typedef enum logic {CLEAR, RUN} state_e;
  state_e state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic ready_q;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic run;
  assign run = (state_q == RUN) && !rst;
  assign ready = ready_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= CLEAR;
      ptr_q <= ADDR_W'(1);
      ready_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + 1'b1;
      if (&ptr_q) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  // Port order in the loop makes the highest-numbered port win each byte.
  always_ff @(posedge clk)
    if (!rst && state_q == CLEAR) regs_q[ptr_q] <= '0;
    else if (run)
      for (int i = 0; i < NUM_WR; i++)
        for (int b = 0; b < NB; b++)
          if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0 && wstrb[i*NB+b])
            regs_q[waddr[i*ADDR_W +: ADDR_W]][b*8 +: 8] <= wdata[i*DATA_W + b*8 +: 8];
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++)
      if (we[i]) busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
    if (alloc_en) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk)
    busy_q <= rst ? '0 : run ? busy_d : busy_q;
  // A completing write both supplies the data and hides the busy flag.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NUM_RD; j++)
      if (run && re[j] && raddr[j*ADDR_W +: ADDR_W] != '0) begin
        rdata[j*DATA_W +: DATA_W] = regs_q[raddr[j*ADDR_W +: ADDR_W]];
        rbusy[j] = busy_q[raddr[j*ADDR_W +: ADDR_W]];
        for (int i = 0; i < NUM_WR; i++)
          if (we[i] && waddr[i*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]) begin
            rbusy[j] = 1'b0;
            for (int b = 0; b < NB; b++)
              if (wstrb[i*NB+b]) rdata[j*DATA_W + b*8 +: 8] = wdata[i*DATA_W + b*8 +: 8];
          end
      end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors for regfile_mp, checked through an expectation queue drained by a monitor.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NW-1:0] we = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic [NW*DW/8-1:0] wstrb = '0;
  logic [NR-1:0] re = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic alloc_en = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic ready;
  typedef struct {
    string name;
    logic [63:0] rd;
    logic [1:0] rb;
    logic rdy;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0;
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ready(ready));
  always #5 clk = ~clk;
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      if ({rdata, rbusy, ready} !== {e.rd, e.rb, e.rdy}) begin
        errs++;
        $display("FAIL %s: got rdata=%h rbusy=%b ready=%b, want rdata=%h rbusy=%b ready=%b",
                 e.name, rdata, rbusy, ready, e.rd, e.rb, e.rdy);
      end
    end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    we = '0;
    wstrb = '0;
    alloc_en = 1'b0;
  endtask
  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    wstrb[p*4 +: 4] = s;
  endtask
  task automatic rd(input int p, input logic en, input logic [4:0] a);
    re[p] = en;
    raddr[p*AW +: AW] = a;
  endtask
  task automatic alloc(input logic [4:0] a);
    alloc_en = 1'b1;
    alloc_addr = a;
  endtask
  task automatic chk(input string n, input logic [31:0] r0, input logic [31:0] r1, input logic [1:0] rb, input logic rdy);
    exp_t e;
    e.name = n;
    e.rd = {r1, r0};
    e.rb = rb;
    e.rdy = rdy;
    q.push_back(e);
  endtask
  initial begin
    rd(0, 1'b1, 5'd1);
    rd(1, 1'b1, 5'd2);
    step;
    chk("reset", 0, 0, 2'b00, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step;
      chk("clear", 0, 0, 2'b00, 1'b0);
    end
    step;
    chk("ready_rise", 0, 0, 2'b00, 1'b1);
    step;
    for (int a = 1; a < 32; a += 2) begin
      rd(0, 1'b1, 5'(a));
      rd(1, 1'b1, 5'(a + 1));
      chk("zero_sweep", 0, 0, 2'b00, 1'b1);
      step;
    end
    idle; wr(0, 5'd5, 32'h11223344, 4'hF); rd(0, 1'b1, 5'd5); rd(1, 1'b1, 5'd5);
    chk("bypass_full", 32'h11223344, 32'h11223344, 2'b00, 1'b1); step;
    idle;
    chk("hold_full", 32'h11223344, 32'h11223344, 2'b00, 1'b1); step;
    idle; wr(0, 5'd5, 32'hAAAAAAAA, 4'h3); wr(1, 5'd5, 32'hBBBBBBBB, 4'h6);
    chk("merge_bypass", 32'h11BBBBAA, 32'h11BBBBAA, 2'b00, 1'b1); step;
    idle;
    chk("merge_hold", 32'h11BBBBAA, 32'h11BBBBAA, 2'b00, 1'b1); step;
    idle; wr(0, 5'd0, 32'hDEADBEEF, 4'hF); wr(1, 5'd0, 32'hDEADBEEF, 4'hF); rd(0, 1'b1, 5'd0); rd(1, 1'b1, 5'd0);
    chk("r0_write", 0, 0, 2'b00, 1'b1); step;
    idle; wr(0, 5'd7, 32'h77, 4'hF); rd(0, 1'b0, 5'd7); rd(1, 1'b1, 5'd7);
    chk("re_off", 0, 32'h77, 2'b00, 1'b1); step;
    idle; rd(0, 1'b1, 5'd0);
    chk("r0_hold", 0, 32'h77, 2'b00, 1'b1); step;
    idle; alloc(5'd9); rd(0, 1'b1, 5'd9); rd(1, 1'b0, 5'd9);
    chk("alloc_same_cycle", 0, 0, 2'b00, 1'b1); step;
    idle;
    chk("alloc_busy", 0, 0, 2'b01, 1'b1); step;
    idle; wr(0, 5'd9, 32'h99, 4'hF);
    chk("write_unbusy", 32'h99, 0, 2'b00, 1'b1); step;
    idle;
    chk("busy_cleared", 32'h99, 0, 2'b00, 1'b1); step;
    idle; alloc(5'd9); wr(0, 5'd9, 32'h1234, 4'h1);
    chk("alloc_and_write", 32'h34, 0, 2'b00, 1'b1); step;
    idle; rd(1, 1'b1, 5'd9);
    chk("set_wins", 32'h34, 32'h34, 2'b11, 1'b1); step;
    idle; alloc(5'd0); rd(0, 1'b1, 5'd0); rd(1, 1'b0, 5'd0);
    chk("alloc_r0_cycle", 0, 0, 2'b00, 1'b1); step;
    idle;
    chk("alloc_r0_ignored", 0, 0, 2'b00, 1'b1); step;
    idle; wr(0, 5'd3, 32'h5, 4'hF); rd(0, 1'b1, 5'd3); rd(1, 1'b1, 5'd9);
    chk("r3_write", 32'h5, 32'h34, 2'b10, 1'b1); step;
    idle; rst = 1'b1;
    chk("reset_mid_run", 0, 0, 2'b00, 1'b1); step;
    rst = 1'b0; wr(0, 5'd3, 32'hFF, 4'hF); alloc(5'd9);
    chk("clear2", 0, 0, 2'b00, 1'b0);
    for (int k = 0; k < 30; k++) begin
      step;
      chk("clear2", 0, 0, 2'b00, 1'b0);
    end
    step;
    idle;
    chk("after_clear2", 0, 0, 2'b00, 1'b1); step;
    chk("after_clear2_hold", 0, 0, 2'b00, 1'b1); step;
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the 2R/1W integer register file in the decode stage.
- Adds configurable read/write port counts, per-byte write strobes, same-cycle write-to-read bypass across all write ports, a per-register busy scoreboard for hazard detection, and a post-reset clear sequencer that zeroes storage.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses; port i in slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, same slicing.
- wstrb  in  NUM_WR*(DATA_W/8)  byte enables per write port.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses.
- rdata  out  NUM_RD*DATA_W  read data, combinational.
- rbusy  out  NUM_RD  scoreboard busy flag for each read address.
- alloc_en  in  1  mark a destination register busy (issue of a producer).
- alloc_addr  in  ADDR_W  register to mark busy.
- ready  out  1  high once the clear sequence is complete.

Behaviour:
- Reset: synchronous, active-high. On a cycle with rst=1: FSM -> CLEAR, clear pointer = 1, all busy bits = 0, ready = 0. rdata and rbusy are forced to 0 while rst=1.
- FSM CLEAR: each cycle writes 0 to regs[ptr] and increments ptr. Transition to RUN on the cycle that ptr = 2**ADDR_W-1 is written. CLEAR therefore takes 2**ADDR_W-1 cycles (31 cycles at the default). ready = 1 only in RUN.
- During CLEAR, the following are ignored and have no effect: we, alloc_en, re. rdata = 0 and rbusy = 0.
- FSM RUN: stays in RUN until rst.
- Write, RUN only: for each port i with we[i]=1 and waddr_i != 0, byte b of regs[waddr_i] is updated with wdata_i byte b where wstrb_i[b]=1; unstrobed bytes keep their value.
  - Same-address writes from several ports: resolved bytewise; highest-numbered port with its strobe set wins.
  - Writes to register 0 are discarded.
- Read, combinational, RUN only. For each read port j:
  - raddr_j = 0 or re[j] = 0 -> rdata_j = 0.
  - Otherwise rdata_j = stored value with same-cycle bypass: each byte is taken from the highest-numbered port i that has we[i]=1, waddr_i = raddr_j and wstrb_i[b]=1; else from storage.
  - Bypass is zero-latency: the value is visible in the same cycle it is written.
- Scoreboard, RUN only: busy[ADDR] updated at posedge.
  - Cleared for every address written by any port with we=1, regardless of strobes.
  - Set for alloc_addr when alloc_en=1.
  - Set and clear of the same address in the same cycle: set wins (new producer).
  - busy[0] is always 0; alloc to register 0 is ignored.
- rbusy_j = re[j] & busy[raddr_j] & ~(some we[i] with waddr_i = raddr_j this cycle). A completing write is treated as not busy because the bypass supplies its data.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from ptr = 1. Storage contents are undefined until ready rises.

Test Plan:
- Reset 1 cycle, then run -> ready=0 for exactly 31 cycles, then 1; reading every register 1..31 returns 0x00000000.
- Port0 writes r5=0x11223344 with strb=1111; same cycle read r5 -> rdata=0x11223344; next cycle, with no write, still 0x11223344.
- r5=0x11223344; port0 writes 0xAAAAAAAA strb=0011 and port1 writes 0xBBBBBBBB strb=0110 to r5 in the same cycle -> read shows 0x11BBBBAA in that cycle and after.
- Write 0xDEADBEEF to r0 on both ports -> read r0 = 0; re=0 on r7 -> rdata = 0 regardless of contents.
- alloc r9 -> rbusy=1 next cycle; write r9 -> rbusy=0 in that same cycle, and busy cleared afterwards; alloc r9 with a simultaneous write to r9 -> busy remains 1.
- Assert rst for 1 cycle during RUN after writing r3=0x5 -> ready drops; after 31 cycles r3 reads 0 and all rbusy = 0; a write issued during CLEAR has no effect.
